// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a valid/ready handshake on both sides.
// Logic, add/sub, compare and unknown ops finish in one cycle. Shifts run
// iteratively at SHIFT_STEP bits per cycle. The result is held until the
// consumer takes it.
// Optional feature: define ALU_EXEC_WORD_EN to enable the 32-bit (op_word)
// variants of ADD/SUB/SLL/SRL/SRA. When it is left undefined, op_word is
// ignored and every op is 64-bit.
module alu_exec_unit #(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            op_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT2 = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;

  localparam logic [6:0] STEP = 7'(SHIFT_STEP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } sh_kind_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] sh_val_q, sh_val_d;
  logic [6:0]      remaining_q, remaining_d;
  sh_kind_e        sh_kind_q, sh_kind_d;
  logic            sh_word_q, sh_word_d;
  logic            ready_en_q, ready_en_d;

  logic            word_mode;
  logic            accept;
  logic            is_shift;
  logic            use_word;
  logic [6:0]      shamt_in;
  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] sub_res;
  logic [XLEN-1:0] sh_init;
  sh_kind_e        sh_kind_in;
  logic [XLEN-1:0] issue_res;
  logic [6:0]      step;
  logic [6:0]      remaining_next;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] shift_final;

  // Sign-extend a 32-bit word result to the full datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

`ifdef ALU_EXEC_WORD_EN
  assign word_mode = op_word;
`else
  assign word_mode = op_word & 1'b0;
`endif

  // in_ready stays low until the first clock after reset has been released.
  assign in_ready  = ready_en_q & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

  // Decode the incoming op and evaluate every single-cycle result.
  always_comb begin
    is_shift   = (alu_op == OP_SLL) | (alu_op == OP_SRL) | (alu_op == OP_SRA);
    use_word   = word_mode & (is_shift | (alu_op == OP_ADD) | (alu_op == OP_SUB));
    shamt_in   = use_word ? {2'b00, operand_b[4:0]} : {1'b0, operand_b[5:0]};
    add_res    = operand_a + operand_b;
    sub_res    = operand_a - operand_b;
    sh_kind_in = SH_SRA;
    sh_init    = operand_a;
    if (alu_op == OP_SLL) begin
      sh_kind_in = SH_SLL;
    end else if (alu_op == OP_SRL) begin
      sh_kind_in = SH_SRL;
      if (use_word) begin
        sh_init = {{(XLEN-32){1'b0}}, operand_a[31:0]};
      end
    end else if (use_word) begin
      sh_init = sext32(operand_a[31:0]);
    end
    issue_res = '0;
    case (alu_op)
      OP_AND:          issue_res = operand_a & operand_b;
      OP_OR:           issue_res = operand_a | operand_b;
      OP_XOR:          issue_res = operand_a ^ operand_b;
      OP_ADD:          issue_res = use_word ? sext32(add_res[31:0]) : add_res;
      OP_SUB:          issue_res = use_word ? sext32(sub_res[31:0]) : sub_res;
      OP_SLT, OP_SLT2: issue_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU:         issue_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      OP_SLL, OP_SRL, OP_SRA:
                       issue_res = use_word ? sext32(sh_init[31:0]) : sh_init;
      default:         issue_res = '0;
    endcase
  end

  // One iteration of the shifter: move by at most STEP bits toward zero remaining.
  always_comb begin
    step           = (remaining_q < STEP) ? remaining_q : STEP;
    remaining_next = remaining_q - step;
    shifted        = sh_val_q;
    case (sh_kind_q)
      SH_SLL:  shifted = sh_val_q << step;
      SH_SRL:  shifted = sh_val_q >> step;
      default: shifted = $signed(sh_val_q) >>> step;
    endcase
    shift_final = sh_word_q ? sext32(shifted[31:0]) : shifted;
  end

  // Next-state logic; a new op is issued from IDLE or back-to-back out of DONE.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    sh_val_d    = sh_val_q;
    remaining_d = remaining_q;
    sh_kind_d   = sh_kind_q;
    sh_word_d   = sh_word_q;
    ready_en_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
      end
      ST_SHIFT: begin
        sh_val_d    = shifted;
        remaining_d = remaining_next;
        if (remaining_next == 7'd0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = shift_final;
          zero_d      = (shift_final == '0);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    if (accept) begin
      if (is_shift && (shamt_in != 7'd0)) begin
        state_d     = ST_SHIFT;
        out_valid_d = 1'b0;
        sh_val_d    = sh_init;
        remaining_d = shamt_in;
        sh_kind_d   = sh_kind_in;
        sh_word_d   = use_word;
      end else begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        result_d    = issue_res;
        zero_d      = (issue_res == '0);
      end
    end
  end

  // State and output registers; reset discards any in-flight or held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sh_val_q    <= '0;
      remaining_q <= 7'd0;
      sh_kind_q   <= SH_SLL;
      sh_word_q   <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      sh_val_q    <= sh_val_d;
      remaining_q <= remaining_d;
      sh_kind_q   <= sh_kind_d;
      sh_word_q   <= sh_word_d;
      ready_en_q  <= ready_en_d;
    end
  end

endmodule
